// File: rtl/reg_file_wr_arbiter.sv
// reg_file_wr_arbiter
//   Owns the single write port of reg_file. After reset it clears registers
//   1..(2^ADDR_WIDTH)-1 to zero, one per cycle. It then shares the write port
//   between two requesters using round-robin arbitration. The rf_* pins are
//   driven straight from registers, and no read port is touched.
//
// Ports
//   clk, rst                    clock and synchronous active-high reset
//   req0_valid/addr/data/ready  requester 0 write channel
//   req1_valid/addr/data/ready  requester 1 write channel
//   rf_wen/rf_waddr/rf_wdata    registered write pins to reg_file
//   init_done                   clear sweep finished, arbitration active
//   wr_count                    writes committed to reg_file (sweep excluded)
//   state_dbg                   current FSM state (0 = INIT, 1 = RUN)
//
// Handshake: a request is taken in the cycle where valid and ready are both
// high. ready is combinational from valid and is never high during the sweep
// or while rst is high. A requester holding valid without ready must keep
// addr/data stable. It may drop valid at any time without side effects.

module reg_file_wr_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0_valid,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    input  logic [DATA_WIDTH-1:0] req0_data,
    output logic                  req0_ready,
    input  logic                  req1_valid,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    input  logic [DATA_WIDTH-1:0] req1_data,
    output logic                  req1_ready,
    output logic                  rf_wen,
    output logic [ADDR_WIDTH-1:0] rf_waddr,
    output logic [DATA_WIDTH-1:0] rf_wdata,
    output logic                  init_done,
    output logic [CNT_WIDTH-1:0]  wr_count,
    output logic                  state_dbg
);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // One bit wider than an address, so the sweep can count past the last
    // register. The terminal value marks the cycle that hands over to RUN.
    localparam logic [ADDR_WIDTH:0] SWEEP_END = {1'b1, {ADDR_WIDTH{1'b0}}};

    state_t                  state;
    state_t                  state_next;
    logic [ADDR_WIDTH:0]     sweep_cnt;
    // Index of the requester that wins the next tie. It is set to the loser
    // after every handshake, so the last winner never wins a tie twice in a
    // row. It starts at requester 0.
    logic                    rr_ptr;
    logic                    grant0;
    logic                    grant1;
    logic                    hs;
    logic [ADDR_WIDTH-1:0]   win_addr;
    logic [DATA_WIDTH-1:0]   win_data;

    always_comb begin
        state_next = state;
        grant0     = 1'b0;
        grant1     = 1'b0;
        case (state)
            ST_INIT: if (sweep_cnt == SWEEP_END) state_next = ST_RUN;
            ST_RUN:  state_next = ST_RUN;
            default: state_next = ST_INIT;
        endcase
        if (init_done && !rst) begin
            if (req0_valid && req1_valid) begin
                grant0 = ~rr_ptr;
                grant1 = rr_ptr;
            end else begin
                grant0 = req0_valid;
                grant1 = req1_valid;
            end
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign hs         = grant0 | grant1;
    assign win_addr   = grant1 ? req1_addr : req0_addr;
    assign win_data   = grant1 ? req1_data : req0_data;
    assign state_dbg  = (state == ST_RUN);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_INIT;
            sweep_cnt <= {{ADDR_WIDTH{1'b0}}, 1'b1};
            rr_ptr    <= 1'b0;
            wr_count  <= '0;
            rf_wen    <= 1'b0;
            rf_waddr  <= '0;
            rf_wdata  <= '0;
            init_done <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                ST_INIT: begin
                    if (sweep_cnt == SWEEP_END) begin
                        rf_wen    <= 1'b0;
                        init_done <= 1'b1;
                    end else begin
                        rf_wen    <= 1'b1;
                        rf_waddr  <= sweep_cnt[ADDR_WIDTH-1:0];
                        rf_wdata  <= '0;
                        sweep_cnt <= sweep_cnt + 1'b1;
                    end
                end
                ST_RUN: begin
                    rf_wen <= 1'b0;
                    if (hs) begin
                        rr_ptr <= grant0;
                        // Register 0 is hard-wired: accept the request but
                        // issue no write, and leave the pins as they were.
                        if (win_addr != '0) begin
                            rf_wen   <= 1'b1;
                            rf_waddr <= win_addr;
                            rf_wdata <= win_data;
                            wr_count <= wr_count + 1'b1;
                        end
                    end
                end
                default: rf_wen <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_reg_file_wr_arbiter.sv
module tb_reg_file_wr_arbiter;

  logic        clk;
  logic        rst;
  logic        req0_valid;
  logic [4:0]  req0_addr;
  logic [31:0] req0_data;
  logic        req0_ready;
  logic        req1_valid;
  logic [4:0]  req1_addr;
  logic [31:0] req1_data;
  logic        req1_ready;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        init_done;
  logic [15:0] wr_count;
  logic        state_dbg;

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  reg_file_wr_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_addr  (req0_addr),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_addr  (req1_addr),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .rf_wen     (rf_wen),
    .rf_waddr   (rf_waddr),
    .rf_wdata   (rf_wdata),
    .init_done  (init_done),
    .wr_count   (wr_count),
    .state_dbg  (state_dbg)
  );

  // Stand-in reg_file: fills with all-ones on request, then takes DUT writes.
  logic [31:0] mem [32];
  logic        mem_fill;
  always @(posedge clk) begin
    if (mem_fill) begin
      for (int i = 0; i < 32; i++) mem[i] <= '1;
    end else if (rf_wen) begin
      mem[rf_waddr] <= rf_wdata;
    end
  end

  // ---------------- reference model ----------------
  // Tracks the cycles since reset release, the last tie-relevant winner
  // (-1 = none yet), the registered outputs expected next, and the count.
  int          m_since;
  bit          m_done;
  int          m_last;
  bit          m_wen;
  logic [4:0]  m_waddr;
  logic [31:0] m_wdata;
  int          m_cnt;
  bit          e0;
  bit          e1;
  int          wen_seen;

  task automatic model_reset();
    m_since = 0; m_done = 0; m_last = -1;
    m_wen = 0; m_waddr = '0; m_wdata = '0; m_cnt = 0;
  endtask

  // Who should be granted in the current cycle.
  task automatic model_grant(output bit g0, output bit g1);
    g0 = 0; g1 = 0;
    if (!rst && m_done) begin
      if (req0_valid && req1_valid) begin
        if (m_last == 0) g1 = 1; else g0 = 1;
      end else begin
        g0 = req0_valid;
        g1 = req1_valid;
      end
    end
  endtask

  // Called at the rising edge: computes what the next cycle must show.
  task automatic model_update();
    bit g0, g1;
    model_grant(g0, g1);
    if (rst) begin
      model_reset();
    end else if (!m_done) begin
      if (m_since < 31) begin
        m_wen = 1; m_waddr = 5'(m_since + 1); m_wdata = '0;
      end else begin
        m_wen = 0; m_done = 1;
      end
      m_since++;
    end else begin
      m_wen = 0;
      if (g0 || g1) begin
        m_last = g1 ? 1 : 0;
        if ((g1 ? req1_addr : req0_addr) != 5'd0) begin
          m_wen   = 1;
          m_waddr = g1 ? req1_addr : req0_addr;
          m_wdata = g1 ? req1_data : req0_data;
          m_cnt   = (m_cnt + 1) % 65536;
        end
      end
    end
  endtask

  // ---------------- scoreboard helpers ----------------
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic check_phase();
    @(negedge clk);
    model_grant(e0, e1);
    chk("req0_ready", 32'(req0_ready), 32'(e0));
    chk("req1_ready", 32'(req1_ready), 32'(e1));
    chk("rf_wen", 32'(rf_wen), 32'(m_wen));
    chk("rf_waddr", 32'(rf_waddr), 32'(m_waddr));
    chk("rf_wdata", rf_wdata, m_wdata);
    chk("init_done", 32'(init_done), 32'(m_done));
    chk("wr_count", 32'(wr_count), 32'(m_cnt));
    if (rf_wen === 1'b1) wen_seen++;
  endtask

  task automatic advance();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic tick();
    check_phase();
    advance();
  endtask

  task automatic drive(input bit v0, input logic [4:0] a0, input logic [31:0] d0,
                       input bit v1, input logic [4:0] a1, input logic [31:0] d1);
    req0_valid = v0; req0_addr = a0; req0_data = d0;
    req1_valid = v1; req1_addr = a1; req1_data = d1;
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    bit          v0;
    logic [4:0]  a0;
    logic [31:0] d0;
    bit          v1;
    logic [4:0]  a1;
    logic [31:0] d1;
    bit          r0;
    bit          r1;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input bit v0, input logic [4:0] a0, input logic [31:0] d0,
                         input bit v1, input logic [4:0] a1, input logic [31:0] d1,
                         input bit r0, input bit r1);
    vec_t v;
    v.v0 = v0; v.a0 = a0; v.d0 = d0; v.v1 = v1; v.a1 = a1; v.d1 = d1;
    v.r0 = r0; v.r1 = r1;
    vecs.push_back(v);
  endtask

  task automatic run_sweep(output int wen_cnt);
    wen_seen = 0;
    for (int i = 0; i < 32; i++) begin
      drive(1'b1, 5'($urandom_range(0, 31)), $urandom, 1'b0, '0, '0);
      tick();
    end
    drive(1'b0, '0, '0, 1'b0, '0, '0);
    tick();
    wen_cnt = wen_seen;
  endtask

  initial begin
    int          wen_cnt;
    int          nonzero;
    logic [31:0] hold0_d, hold1_d;
    logic [4:0]  hold0_a, hold1_a;
    bit          hv0, hv1;

    drive(1'b0, '0, '0, 1'b0, '0, '0);
    rst      = 1'b1;
    mem_fill = 1'b1;
    @(posedge clk);
    model_reset();
    #1;
    mem_fill = 1'b0;
    req0_valid = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    // Sweep: 31 writes of zero to 1..31, readies held low, register 0 kept.
    run_sweep(wen_cnt);
    chk("sweep_wen_cycles", 32'(wen_cnt), 32'd31);
    nonzero = 0;
    for (int i = 1; i < 32; i++) if (mem[i] !== 32'd0) nonzero++;
    chk("sweep_cleared_regs", 32'(nonzero), 32'd0);
    chk("sweep_reg0_untouched", mem[0], 32'hFFFF_FFFF);
    chk("sweep_init_done", 32'(init_done), 32'd1);

    // Same-address tie, alternation, single write, address-0 write.
    add_vec(1, 5'd9, 32'd1, 1, 5'd9, 32'd2, 1, 0);
    add_vec(0, 5'd0, 32'd0, 1, 5'd9, 32'd2, 0, 1);
    for (int i = 0; i < 3; i++) begin
      add_vec(1, 5'd3, 32'hA0 + 32'(i), 1, 5'd4, 32'hB0 + 32'(i), 1, 0);
      add_vec(1, 5'd3, 32'hA1 + 32'(i), 1, 5'd4, 32'hB0 + 32'(i), 0, 1);
    end
    add_vec(1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 32'd0, 1, 0);
    add_vec(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 0, 0);
    add_vec(0, 5'd0, 32'd0, 1, 5'd0, 32'd7, 0, 1);
    add_vec(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 0, 0);
    add_vec(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 0, 0);

    foreach (vecs[i]) begin
      drive(vecs[i].v0, vecs[i].a0, vecs[i].d0, vecs[i].v1, vecs[i].a1, vecs[i].d1);
      check_phase();
      chk($sformatf("vec%0d_ready0", i), 32'(req0_ready), 32'(vecs[i].r0));
      chk($sformatf("vec%0d_ready1", i), 32'(req1_ready), 32'(vecs[i].r1));
      advance();
    end
    chk("reg9_final", mem[9], 32'd2);
    chk("reg5_value", mem[5], 32'hDEADBEEF);
    chk("reg0_after_addr0", mem[0], 32'hFFFF_FFFF);
    chk("wr_count_directed", 32'(wr_count), 32'd9);

    // Reset for one cycle while req0 streams writes.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 5'd12, 32'hC0 + 32'(i), 1'b0, '0, '0);
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midreset_init_done", 32'(init_done), 32'd0);
    chk("midreset_wr_count", 32'(wr_count), 32'd0);
    chk("midreset_wen", 32'(rf_wen), 32'd0);
    run_sweep(wen_cnt);
    chk("resweep_wen_cycles", 32'(wen_cnt), 32'd31);

    // Random traffic against the model; pending requests hold addr/data.
    hv0 = 0; hv1 = 0; hold0_a = '0; hold1_a = '0; hold0_d = '0; hold1_d = '0;
    for (int n = 0; n < 400; n++) begin
      if (!hv0 || $urandom_range(0, 7) == 0) begin
        hv0 = ($urandom_range(0, 2) != 0);
        hold0_a = 5'($urandom_range(0, 31));
        hold0_d = $urandom;
      end
      if (!hv1 || $urandom_range(0, 7) == 0) begin
        hv1 = ($urandom_range(0, 2) != 0);
        hold1_a = ($urandom_range(0, 3) == 0) ? hold0_a : 5'($urandom_range(0, 31));
        hold1_d = $urandom;
      end
      drive(hv0, hold0_a, hold0_d, hv1, hold1_a, hold1_d);
      check_phase();
      if (e0) hv0 = 0;
      if (e1) hv1 = 0;
      advance();
    end
    drive(1'b0, '0, '0, 1'b0, '0, '0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
